// File: rtl/hex_pkg.sv
// Shared types and helpers for the hex display controller.
package hex_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;
  typedef logic [1:0] req_idx_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Next round-robin position after idx, wrapping at n requesters.
  function automatic req_idx_t rr_next(input req_idx_t idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_driver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_rr_arbiter.sv
// Round-robin grant among NUM_REQ requesters; pointer moves past the winner on grant.
module hex_rr_arbiter
  import hex_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         winner
);

  req_idx_t ptr;
  logic     found;

  // Scan distances from the pointer in increasing order; first valid wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && valid[i] && ((i - int'(ptr) + NUM_REQ) % NUM_REQ) == k) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            winner   = req_idx_t'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= rr_next(winner, NUM_REQ);
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Shared 7-segment bank: arbitrated digit writes plus a scanner that refreshes one digit at a time.
// Optional blinking is enabled with the HEX_CTRL_BLINK_EN macro.
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_REQ    = 2,
  parameter int SCAN_DIV   = 4,
`ifdef HEX_CTRL_BLINK_EN
  parameter int BLINK_DIV  = 4194304,
`endif
  localparam int AW = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_all,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*4-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_blank,
`ifdef HEX_CTRL_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS*7-1:0] hex_out,
  output logic                    busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]            winner;
  logic [AW-1:0]         wr_addr;
  nibble_t               wr_data;
  logic                  wr_blank;
  logic                  wr_ok;
  nibble_t               value [NUM_DIGITS];
  seg_t                  seg_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] dirty;
  logic [SW-1:0]         scan_cnt;
  logic [AW-1:0]         digit_ptr;
  logic                  refresh;
  seg_t                  dec_seg;
  seg_t                  new_seg;

  hex_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (!clear_all),
    .valid   (req_valid),
    .grant   (req_ready),
    .winner  (winner)
  );

  always_comb begin
    wr_addr  = '0;
    wr_data  = '0;
    wr_blank = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        wr_addr  = req_addr[i*AW +: AW];
        wr_data  = req_data[i*4 +: 4];
        wr_blank = req_blank[i];
      end
    end
  end

  // Out-of-range addresses still complete the handshake but store nothing.
  assign wr_ok   = (|req_ready) && (int'(wr_addr) < NUM_DIGITS);
  assign refresh = (scan_cnt == SW'(SCAN_DIV - 1));

  hex_driver u_hex (
    .nibble (value[digit_ptr]),
    .seg    (dec_seg)
  );

`ifdef HEX_CTRL_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    new_seg = dec_seg;
    if (blank[digit_ptr]) new_seg = SEG_BLANK;
`ifdef HEX_CTRL_BLINK_EN
    if (blink_mask[digit_ptr] && blink_phase) new_seg = SEG_BLANK;
`endif
  end

  // Write/clear assignments come after the refresh so a same-cycle write keeps dirty set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_ptr <= '0;
      blank     <= '1;
      dirty     <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        value[d]   <= '0;
        seg_reg[d] <= SEG_BLANK;
      end
    end else begin
      if (refresh) begin
        scan_cnt           <= '0;
        seg_reg[digit_ptr] <= new_seg;
        dirty[digit_ptr]   <= 1'b0;
        digit_ptr          <= (digit_ptr == AW'(NUM_DIGITS - 1)) ? '0 : digit_ptr + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (clear_all) begin
        blank <= '1;
        dirty <= '1;
      end else if (wr_ok) begin
        value[wr_addr] <= wr_data;
        blank[wr_addr] <= wr_blank;
        dirty[wr_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    hex_out = '0;
    for (int d = 0; d < NUM_DIGITS; d++) hex_out[d*7 +: 7] = seg_reg[d];
  end

  assign busy = |dirty;

endmodule
